pll_rst_seq: RTL
================

# pll_rst_seq

Clock/reset sequencer for the PLL and the system reset tree. Drives the PLL reset and waits for a debounced LOCKED. Releases the core and peripheral resets in two timed stages. On loss of lock it re-asserts all resets and re-runs the sequence, counting relock events. Sits beside the PLL instance in the system-init layer and replaces the bare two-flop reset release.

## Interface
- PLL_RST_CYC, 8: cycles `o_pll_reset` is held high per PLL reset pulse (≥1).
- LOCK_TIMEOUT_CYC, 65536: cycles to wait for lock before re-pulsing the PLL reset.
- LOCK_STABLE_CYC, 1024: consecutive synchronized-lock-high cycles required before any reset is released (≥1).
- STAGE_GAP_CYC, 16: cycles between core release and peripheral release (≥1).
- MAX_RETRY, 3: consecutive lock timeouts tolerated (used only with the retry-limit option).
- clk_in  input  1  free-running reference clock (not a PLL output).
- RSTn  input  1  asynchronous, active-low reset.
- i_locked  input  1  PLL LOCKED; asynchronous, passed through a 2-FF synchronizer.
- o_pll_reset  output  1  PLL RESET, active-high.
- o_rst_n_core  output  1  core reset, active-low.
- o_rst_n_periph  output  1  peripheral reset, active-low.
- o_ready  output  1  sequence complete, clocks valid.
- o_fail  output  1  retry limit exhausted (constant 0 when the option is off).
- o_relock_cnt  output  8  count of lock losses in RUN, saturating at 255.

## Operation
- States: PLL_RST, WAIT_LOCK, STABLE, REL_CORE, RUN, FAIL (FAIL exists only with the option).
- PLL_RST: `o_pll_reset`=1 for PLL_RST_CYC cycles, then go to WAIT_LOCK.
- WAIT_LOCK: the timeout counter runs.
  - Synchronized lock seen high: go to STABLE.
  - Counter reaches LOCK_TIMEOUT_CYC−1: go to PLL_RST and increment the retry counter.
- STABLE: the stability counter increments while synchronized lock is high.
  - Any low cycle: return to WAIT_LOCK with both counters cleared.
  - Counter reaches LOCK_STABLE_CYC−1: go to REL_CORE and set `o_rst_n_core`=1; clear the retry counter.
- REL_CORE: hold for STAGE_GAP_CYC cycles, then go to RUN and set `o_rst_n_periph`=1 and `o_ready`=1 on the same edge.
  - Lock loss: handled as in RUN.
- RUN: hold until lock is lost.
  - Lock loss (synchronized lock low): on the next edge set `o_rst_n_core`=0, `o_rst_n_periph`=0 and `o_ready`=0 together, increment `o_relock_cnt` (saturating), then go to PLL_RST.
- Lock loss in STABLE or WAIT_LOCK does not increment `o_relock_cnt`.
- Counters are sized by $clog2 of their largest parameter; none wrap, since all compare against terminal count.

## Timing
- Reset values:
  - `o_pll_reset`=1
  - `o_rst_n_core`=0
  - `o_rst_n_periph`=0
  - `o_ready`=0
  - `o_fail`=0
  - `o_relock_cnt`=0
  - FSM in PLL_RST with counters at 0.
- All outputs are registered. No combinational path from any input to any output.
- `o_pll_reset` falls PLL_RST_CYC edges after RSTn deasserts.
- `i_locked` → internal lock: 2-edge synchronizer latency.
- `o_rst_n_core` rises LOCK_STABLE_CYC+2 edges after `i_locked` rises, provided the lock holds.
- `o_rst_n_periph`/`o_ready` rise STAGE_GAP_CYC edges after `o_rst_n_core`.
- Lock drop in RUN → resets asserted 3 edges after `i_locked` falls (2 sync + 1 register).
- RSTn asserted mid-sequence: all outputs return to their reset values immediately (asynchronous), including `o_relock_cnt`.
- Lock loss and lock timeout are mutually exclusive by state. A lock glitch shorter than the synchronizer capture window may be missed; this is acceptable.

## Configuration
- `PLL_RST_SEQ_RETRY_LIMIT_EN` defined:
  - MAX_RETRY consecutive WAIT_LOCK timeouts send the FSM to FAIL.
  - FAIL behaviour: `o_fail`=1, `o_pll_reset`=1, all resets asserted, `o_ready`=0; left only by RSTn.
- Undefined: timeouts retry forever, `o_fail` is tied 0, and the retry counter is not built.

## Test plan
Parameters for all scenarios: PLL_RST_CYC=4, LOCK_TIMEOUT_CYC=64, LOCK_STABLE_CYC=16, STAGE_GAP_CYC=4, MAX_RETRY=2.
- Clean power-up: release RSTn, raise `i_locked` 10 cycles later and hold it.
  - Required: `o_pll_reset` low after edge 4; `o_rst_n_core` rises 18 edges after `i_locked` rises; `o_rst_n_periph`/`o_ready` rise 4 edges after that; `o_relock_cnt`=0.
- Lock chatter: `i_locked` pulses high for 10 cycles, low for 1, then stays high.
  - Required: no reset is released until 18 edges after the final rise.
- Lock loss in RUN: drop `i_locked` for 5 cycles, then restore it.
  - Required: all resets are asserted 3 edges after the drop; `o_pll_reset` pulses for 4 cycles; `o_relock_cnt`=1; the full sequence repeats.
- Timeout without the option: keep `i_locked`=0.
  - Required: an `o_pll_reset` 4-cycle pulse every 68 cycles, indefinitely; `o_fail`=0.
- Timeout with `PLL_RST_SEQ_RETRY_LIMIT_EN`: keep `i_locked`=0.
  - Required: `o_fail`=1 after the 2nd timeout; it stays set even when `i_locked` later rises; only an RSTn pulse clears it.
- Mid-sequence reset: assert RSTn while in REL_CORE.
  - Required: in the same cycle, `o_rst_n_core`=0, `o_pll_reset`=1, and `o_relock_cnt`=0.

Source files
------------

// File: rtl/pll_rst_seq.sv
// PLL reset / lock-qualified two-stage reset-release sequencer with relock counting.
// Optional retry limit: define PLL_RST_SEQ_RETRY_LIMIT_EN to latch o_fail after MAX_RETRY lock timeouts.
module pll_rst_seq #(
  parameter int unsigned PLL_RST_CYC      = 8,
  parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned STAGE_GAP_CYC    = 16,
  parameter int unsigned MAX_RETRY        = 3
) (
  input  logic       clk_in,
  input  logic       RSTn,
  input  logic       i_locked,
  output logic       o_pll_reset,
  output logic       o_rst_n_core,
  output logic       o_rst_n_periph,
  output logic       o_ready,
  output logic       o_fail,
  output logic [7:0] o_relock_cnt
);

  localparam int unsigned MAX_AB = (PLL_RST_CYC > LOCK_TIMEOUT_CYC) ? PLL_RST_CYC : LOCK_TIMEOUT_CYC;
  localparam int unsigned MAX_CD = (LOCK_STABLE_CYC > STAGE_GAP_CYC) ? LOCK_STABLE_CYC : STAGE_GAP_CYC;
  localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CW-1:0] PLL_TC    = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_TC = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STABLE_TC = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] GAP_TC    = CW'(STAGE_GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_REL_CORE  = 3'd3,
    S_RUN       = 3'd4
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
    ,S_FAIL     = 3'd5
`endif
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          sync1, locked;
  logic          relock_inc;
  logic          pll_nxt, core_nxt, run_nxt;

`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
  localparam int unsigned RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_TC = RW'(MAX_RETRY - 1);
  logic [RW-1:0] retry, retry_nxt;
`endif

  always_ff @(posedge clk_in or negedge RSTn) begin
    if (!RSTn) begin
      sync1  <= 1'b0;
      locked <= 1'b0;
    end else begin
      sync1  <= i_locked;
      locked <= sync1;
    end
  end

  always_ff @(posedge clk_in or negedge RSTn) begin
    if (!RSTn) begin
      state <= S_PLL_RST;
      cnt   <= '0;
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
      retry <= '0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
      retry <= retry_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    relock_inc = 1'b0;
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
    retry_nxt  = retry;
`endif
    case (state)
      S_PLL_RST: begin
        if (cnt == PLL_TC) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        // The lock-high sample that leaves WAIT_LOCK is the first of the stability window.
        if (locked) begin
          if (LOCK_STABLE_CYC == 1) begin
            state_nxt = S_REL_CORE;
            cnt_nxt   = '0;
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
            retry_nxt = '0;
`endif
          end else begin
            state_nxt = S_STABLE;
            cnt_nxt   = CW'(1);
          end
        end else if (cnt == TIMEOUT_TC) begin
          cnt_nxt = '0;
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
          if (retry == RETRY_TC) begin
            state_nxt = S_FAIL;
          end else begin
            state_nxt = S_PLL_RST;
            retry_nxt = retry + 1'b1;
          end
`else
          state_nxt = S_PLL_RST;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_STABLE: begin
        if (!locked) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_TC) begin
          state_nxt = S_REL_CORE;
          cnt_nxt   = '0;
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
          retry_nxt = '0;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_REL_CORE: begin
        if (!locked) begin
          state_nxt  = S_PLL_RST;
          cnt_nxt    = '0;
          relock_inc = 1'b1;
        end else if (cnt == GAP_TC) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (!locked) begin
          state_nxt  = S_PLL_RST;
          cnt_nxt    = '0;
          relock_inc = 1'b1;
        end
      end
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
      S_FAIL: begin
        state_nxt = S_FAIL;
        cnt_nxt   = '0;
      end
`endif
      default: begin
        state_nxt = S_PLL_RST;
        cnt_nxt   = '0;
      end
    endcase

    // Outputs are registered from the next state so they change on the transition edge.
    pll_nxt  = (state_nxt == S_PLL_RST);
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
    if (state_nxt == S_FAIL) pll_nxt = 1'b1;
`endif
    core_nxt = (state_nxt == S_REL_CORE) || (state_nxt == S_RUN);
    run_nxt  = (state_nxt == S_RUN);
  end

  always_ff @(posedge clk_in or negedge RSTn) begin
    if (!RSTn) begin
      o_pll_reset    <= 1'b1;
      o_rst_n_core   <= 1'b0;
      o_rst_n_periph <= 1'b0;
      o_ready        <= 1'b0;
      o_relock_cnt   <= '0;
    end else begin
      o_pll_reset    <= pll_nxt;
      o_rst_n_core   <= core_nxt;
      o_rst_n_periph <= run_nxt;
      o_ready        <= run_nxt;
      if (relock_inc && (o_relock_cnt != 8'hFF))
        o_relock_cnt <= o_relock_cnt + 8'd1;
    end
  end

`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
  always_ff @(posedge clk_in or negedge RSTn) begin
    if (!RSTn) o_fail <= 1'b0;
    else       o_fail <= (state_nxt == S_FAIL);
  end
`else
  assign o_fail = 1'b0;
`endif

endmodule
